mem_load_unit: RTL and testbench

MEM_LOAD_UNIT -- requirements
Module: mem_load_unit

---
 rtl/mem_load_unit_pkg.sv | 35 +++
 rtl/mem_load_unit_extend.sv | 28 ++
 rtl/mem_load_unit.sv | 79 +++++++
 tb/tb_mem_load_unit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_load_unit_pkg.sv
// Shared CPU definitions for the load unit: size/state encodings, request
// record and the default acknowledge timeout.
package mem_load_unit_pkg;
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_DONE = 2'b10,
    S_ERR  = 2'b11
  } state_e;

  localparam int DEF_TIMEOUT = 16;

  typedef struct packed {
    logic [31:0] addr;
    size_e       size;
    logic        sext;
  } load_req_t;

  // Reserved size is rejected alongside misaligned sub-word/word accesses.
  function automatic logic bad_access(input size_e size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: bad_access = 1'b0;
      SZ_HALF: bad_access = lo[0];
      SZ_WORD: bad_access = |lo;
      default: bad_access = 1'b1;
    endcase
  endfunction
endpackage

// File: rtl/mem_load_unit_extend.sv
// Lane select and sign/zero extension of a little-endian read word.
module load_extend
  import mem_load_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  size_e       size,
  input  logic        sext,
  output logic [31:0] data
);
  logic [3:0][7:0]  bytes;
  logic [1:0][15:0] halves;
  logic [7:0]       b;
  logic [15:0]      h;

  always_comb begin
    bytes  = rdata;
    halves = rdata;
    b      = bytes[lane];
    h      = halves[lane[1]];
    data   = rdata;
    case (size)
      SZ_BYTE: data = {{24{sext & b[7]}}, b};
      SZ_HALF: data = {{16{sext & h[15]}}, h};
      default: data = rdata;
    endcase
  end
endmodule

// File: rtl/mem_load_unit.sv
// Load unit: latches a load request, issues one word read to data memory,
// extends the returned data, and flags misaligned/reserved/timed-out accesses.
module mem_load_unit
  import mem_load_unit_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic [31:0] Addr,
  input  logic [1:0]  Size,
  input  logic        SignExt,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] DataOut
);
  localparam int CW = $clog2(TIMEOUT + 1);

  state_e        state, state_n;
  load_req_t     req_q;
  logic [CW-1:0] cnt;
  logic [31:0]   ext_data;

  load_extend u_ext (
    .rdata (mem_rdata),
    .lane  (req_q.addr[1:0]),
    .size  (req_q.size),
    .sext  (req_q.sext),
    .data  (ext_data)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_IDLE;
      req_q   <= '0;
      cnt     <= '0;
      DataOut <= '0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && start)
        req_q <= '{addr: Addr, size: size_e'(Size), sext: SignExt};
      // Counter is held at zero outside REQ, so every REQ entry starts fresh.
      if (state == S_REQ) begin
        if (!mem_ack) cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
      if (state == S_REQ && mem_ack) DataOut <= ext_data;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (start)
          state_n = bad_access(size_e'(Size), Addr[1:0]) ? S_ERR : S_REQ;
      end
      S_REQ: begin
        // An ack in the final allowed cycle still wins over the timeout.
        if (mem_ack)                        state_n = S_DONE;
        else if (cnt == CW'(TIMEOUT - 1))   state_n = S_ERR;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign mem_req  = (state == S_REQ);
  assign mem_addr = {req_q.addr[31:2], 2'b00};
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);
  assign err      = (state == S_ERR);
endmodule

// File: tb/tb_mem_load_unit.sv
// Scoreboard bench for mem_load_unit built with a 4-cycle acknowledge timeout.
module tb_mem_load_unit;
  logic        CLK = 1'b0;
  logic        RST, start, SignExt, mem_ack;
  logic [31:0] Addr, mem_rdata;
  logic [1:0]  Size;
  logic        mem_req, busy, done, err;
  logic [31:0] mem_addr, DataOut;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          passed = 0;
  logic [31:0] last_data = 32'h0;

  always #5 CLK = ~CLK;

  mem_load_unit #(.TIMEOUT(4)) dut (
    .CLK(CLK), .RST(RST), .start(start), .Addr(Addr), .Size(Size),
    .SignExt(SignExt), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy), .done(done),
    .err(err), .DataOut(DataOut)
  );

  function automatic logic [31:0] model(input logic [31:0] a, input logic [1:0] sz,
                                        input logic sx, input logic [31:0] rd);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = rd >> (a[1:0] * 8);
    b  = sh[7:0];
    sh = rd >> (a[1] * 16);
    h  = sh[15:0];
    if (sz == 2'b00) return sx ? {{24{b[7]}}, b} : {24'h0, b};
    if (sz == 2'b01) return sx ? {{16{h[15]}}, h} : {16'h0, h};
    return rd;
  endfunction

  // wait_n: unacked REQ cycles before the ack (-1 = never). hammer keeps
  // start high with a bogus request while the unit is busy.
  task automatic run_load(input string name, input logic [31:0] a, input logic [1:0] sz,
                          input logic sx, input logic [31:0] rd, input int wait_n,
                          input logic [31:0] exp_data, input logic exp_err,
                          input int exp_lat, input logic hammer);
    exp_t e;
    int   lat, reqs;
    logic addr_ok;
    @(negedge CLK);
    start = 1'b1; Addr = a; Size = sz; SignExt = sx; mem_ack = 1'b0; mem_rdata = ~rd;
    e.data = exp_data; e.err = exp_err;
    sb.push_back(e);
    @(negedge CLK);
    lat = 1; reqs = 0; addr_ok = 1'b1;
    if (hammer) begin
      Addr = 32'h0000_0FFF; Size = 2'b11; SignExt = ~sx;
    end else begin
      start = 1'b0;
    end
    while (!(done || err) && lat < 64) begin
      if (mem_req) begin
        if (mem_addr !== {a[31:2], 2'b00}) addr_ok = 1'b0;
        mem_ack   = (reqs == wait_n);
        mem_rdata = (reqs == wait_n) ? rd : ~rd;
        reqs++;
      end else begin
        mem_ack = 1'b0;
      end
      @(negedge CLK);
      lat++;
    end
    mem_ack = 1'b0; start = 1'b0;
    checks++;
    if (!(done || err)) begin
      $display("FAIL %s no_completion: waited %0d cycles without done/err", name, lat);
      void'(sb.pop_front());
      return;
    end
    passed++;
    e = sb.pop_front();
    checks++;
    if (err !== e.err || done !== !e.err)
      $display("FAIL %s outcome: done=%b err=%b, required err=%b", name, done, err, e.err);
    else passed++;
    checks++;
    if (DataOut !== e.data)
      $display("FAIL %s data: DataOut=%h, required %h", name, DataOut, e.data);
    else passed++;
    checks++;
    if (lat !== exp_lat || reqs !== exp_lat - 1)
      $display("FAIL %s latency: lat=%0d reqs=%0d, required lat=%0d reqs=%0d",
               name, lat, reqs, exp_lat, exp_lat - 1);
    else passed++;
    checks++;
    if (!addr_ok) $display("FAIL %s mem_addr: not %h/stable during REQ", name, {a[31:2], 2'b00});
    else passed++;
    @(negedge CLK);
    checks++;
    if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0 || mem_req !== 1'b0 || DataOut !== e.data)
      $display("FAIL %s after_pulse: done=%b err=%b busy=%b mem_req=%b DataOut=%h, required 0 0 0 0 %h",
               name, done, err, busy, mem_req, DataOut, e.data);
    else passed++;
    if (!exp_err) last_data = exp_data;
  endtask

  task automatic test_reset();
    RST = 1'b1; start = 1'b1; Addr = 32'h100; Size = 2'b10; SignExt = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    repeat (3) @(negedge CLK);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || mem_req !== 1'b0 || DataOut !== 32'h0)
      $display("FAIL reset_state: busy=%b done=%b err=%b mem_req=%b DataOut=%h, required all 0",
               busy, done, err, mem_req, DataOut);
    else passed++;
    start = 1'b0; mem_ack = 1'b0;
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if (busy !== 1'b0) $display("FAIL reset_idle: busy=%b, required 0", busy);
    else passed++;
  endtask

  task automatic test_spec_loads();
    run_load("byte_signed", 32'h103, 2'b00, 1'b1, 32'h8011_2233, 0, 32'hFFFF_FF80, 1'b0, 2, 1'b0);
    run_load("half_unsigned", 32'h102, 2'b01, 1'b0, 32'hBEEF_1234, 3, 32'h0000_BEEF, 1'b0, 5, 1'b0);
    run_load("misaligned_word", 32'h101, 2'b10, 1'b0, 32'h5555_5555, 0, last_data, 1'b1, 1, 1'b0);
    run_load("timeout", 32'h200, 2'b10, 1'b0, 32'h0, -1, last_data, 1'b1, 5, 1'b0);
    run_load("ack_at_timeout", 32'h204, 2'b10, 1'b0, 32'h1234_5678, 3, 32'h1234_5678, 1'b0, 5, 1'b0);
  endtask

  task automatic test_boundaries();
    run_load("byte_lane0_zext", 32'h40, 2'b00, 1'b0, 32'h7F80_01FE, 0, 32'h0000_00FE, 1'b0, 2, 1'b0);
    run_load("byte_lane1_sext", 32'h41, 2'b00, 1'b1, 32'h7F80_01FE, 1, 32'h0000_0001, 1'b0, 3, 1'b0);
    run_load("byte_lane2_sext", 32'h42, 2'b00, 1'b1, 32'h7F80_01FE, 0, 32'hFFFF_FF80, 1'b0, 2, 1'b0);
    run_load("half_lane0_sext", 32'h44, 2'b01, 1'b1, 32'h7FFF_8001, 2, 32'hFFFF_8001, 1'b0, 4, 1'b0);
    run_load("half_lane1_sext", 32'h46, 2'b01, 1'b1, 32'h7FFF_8001, 0, 32'h0000_7FFF, 1'b0, 2, 1'b0);
    run_load("half_misaligned", 32'h45, 2'b01, 1'b0, 32'h0, 0, last_data, 1'b1, 1, 1'b0);
    run_load("reserved_size", 32'h48, 2'b11, 1'b0, 32'h0, 0, last_data, 1'b1, 1, 1'b0);
  endtask

  task automatic test_random_loads();
    logic [31:0] a, rd;
    logic [1:0]  sz;
    logic        sx;
    int          w;
    for (int i = 0; i < 8; i++) begin
      sz = 2'($urandom_range(0, 2));
      sx = 1'($urandom_range(0, 1));
      a  = $urandom & 32'h0000_FFFF;
      if (sz == 2'b01) a[0] = 1'b0;
      if (sz == 2'b10) a[1:0] = 2'b00;
      rd = $urandom;
      w  = $urandom_range(0, 3);
      run_load("random", a, sz, sx, rd, w, model(a, sz, sx, rd), 1'b0, w + 2, 1'b0);
    end
  endtask

  task automatic test_start_while_busy();
    run_load("start_while_busy", 32'h301, 2'b00, 1'b1, 32'h0000_9A00, 2, 32'hFFFF_FF9A, 1'b0, 4, 1'b1);
  endtask

  task automatic test_reset_mid_req();
    @(negedge CLK);
    start = 1'b1; Addr = 32'h400; Size = 2'b10; SignExt = 1'b0;
    @(negedge CLK);
    start = 1'b0;
    checks++;
    if (mem_req !== 1'b1) $display("FAIL midreset_in_req: mem_req=%b, required 1", mem_req);
    else passed++;
    RST = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(negedge CLK);
    checks++;
    if (busy !== 1'b0 || mem_req !== 1'b0 || done !== 1'b0 || err !== 1'b0 || DataOut !== 32'h0)
      $display("FAIL midreset_state: busy=%b mem_req=%b done=%b err=%b DataOut=%h, required 0 0 0 0 0",
               busy, mem_req, done, err, DataOut);
    else passed++;
    RST = 1'b0; mem_ack = 1'b0;
    @(negedge CLK);
    checks++;
    if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0)
      $display("FAIL midreset_no_pulse: done=%b err=%b busy=%b, required 0 0 0", done, err, busy);
    else passed++;
    last_data = 32'h0;
    run_load("after_reset", 32'h404, 2'b10, 1'b0, 32'h0BAD_F00D, 0, 32'h0BAD_F00D, 1'b0, 2, 1'b0);
  endtask

  initial begin
    test_reset();
    test_spec_loads();
    test_boundaries();
    test_start_while_busy();
    test_random_loads();
    test_reset_mid_req();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
